// File: rtl/rom_pkg.sv
// Shared types and sizes for the ROM stream reader.
package rom_pkg;

  localparam int unsigned ROM_AW = 3;
  localparam int unsigned ROM_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rom_rd_state_t;

endpackage

// File: rtl/rom_out_stage.sv
// Single-entry valid/ready holding register for captured ROM words.
module rom_out_stage
  import rom_pkg::*;
#(
  parameter int unsigned DW = ROM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic          flush,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  // Flush beats load; a load may replace a word that is leaving this cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Walks a run of consecutive ROM addresses and streams each word out
// on a valid/ready handshake, pulsing done after the last acceptance.
module rom_stream_reader
  import rom_pkg::*;
#(
  parameter int unsigned AW = ROM_AW,
  parameter int unsigned DW = ROM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CW = AW + 1;

  rom_rd_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          flush_c;
  logic          load_c;
  logic          accept_c;
  logic          stg_valid;

  assign accept_c = stg_valid && out_ready;
  // Capture whenever the holding register is free or emptying this cycle.
  assign load_c   = (state_q == RUN) && !abort && (!stg_valid || out_ready)
                    && (rem_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !abort && (count != '0)) state_d = RUN;
      end
      RUN: begin
        if (abort)                                state_d = IDLE;
        else if (load_c && (rem_q == CW'(1)))     state_d = DRAIN;
      end
      DRAIN: begin
        if (abort || accept_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          addr_d = start_addr;
          rem_d  = count;
          busy_d = (count != '0);
          done_d = (count == '0);
        end
      end
      RUN: begin
        if (abort) begin
          flush_c = 1'b1;
          busy_d  = 1'b0;
          rem_d   = '0;
        end else if (load_c) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - CW'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          flush_c = 1'b1;
          busy_d  = 1'b0;
        end else if (accept_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        flush_c = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  rom_out_stage #(
    .DW(DW)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .data_in  (rom_data),
    .flush    (flush_c),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(stg_valid)
  );

  assign out_valid = stg_valid;
  assign rom_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader with a behavioural ROM and run model.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] start_addr = 3'd0;
  logic [3:0] count = 4'd0;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;

  logic [7:0] rom_mem [8];
  logic [7:0] exp_q [$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  bit prev_hold = 1'b0;
  bit prev_abort = 1'b0;

  rom_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .count     (count),
    .abort     (abort),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rom_data = rom_mem[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic drive_ready(input int mode, input int k, input int hold);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (k >= hold);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Monitor: every presented word must match the head of the expected stream.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_excl_valid", 32'(out_valid), 32'd0);
      end
      if (prev_hold && !prev_abort) check("valid_held", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word (cycle %0d)", out_data, cyc);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
            last_acc_cyc = cyc;
          end
        end
      end
    end
    prev_hold  = rst_n && out_valid && !out_ready;
    prev_abort = abort;
  end

  task automatic run(input logic [2:0] sa, input logic [3:0] cnt, input int mode,
                     input int hold, input bit poke);
    int c0;
    int d0;
    bit got;
    logic [7:0] first;
    first = rom_mem[sa];
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back(rom_mem[3'(sa + 3'(i))]);
    d0 = done_cnt;
    @(posedge clk); #1;
    out_ready  = drive_ready(mode, 0, hold);
    start      = 1'b1;
    start_addr = sa;
    count      = cnt;
    c0         = cyc;
    @(posedge clk); #1;
    start      = 1'b0;
    start_addr = 3'($urandom);
    count      = 4'($urandom_range(0, 8));
    check("busy_after_start", 32'(busy), 32'(cnt != 4'd0));
    check("rom_addr_after_start", 32'(rom_addr), 32'(sa));
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
      out_ready = drive_ready(mode, k, hold);
      if (hold > 0 && k == hold) check("hold_word", {23'd0, out_valid, out_data}, {23'd0, 1'b1, first});
      if (poke && k == 1 && busy) begin
        start      = 1'b1;
        start_addr = 3'($urandom);
        count      = 4'($urandom_range(1, 8));
      end
    end
    start = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected done (sa=%0d cnt=%0d)", sa, cnt);
      exp_q.delete();
    end else begin
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("done_timing", 32'(done_cyc), (cnt == 4'd0) ? 32'(c0 + 1) : 32'(last_acc_cyc + 1));
      if (mode == 0 && cnt != 4'd0) check("throughput", 32'(done_cyc), 32'(c0 + int'(cnt) + 2));
      check("busy_after_done", 32'(busy), 32'd0);
      check("rom_addr_end", 32'(rom_addr), 32'(3'(sa + 3'(cnt))));
    end
    repeat (2) @(posedge clk);
    #1;
    check("done_single", 32'(done_cnt - d0), 32'd1);
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic abort_run(input logic [2:0] sa);
    int d0;
    int a0;
    bit got;
    d0 = done_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(rom_mem[3'(sa + 3'(i))]);
    @(posedge clk); #1;
    out_ready  = 1'b1;
    start      = 1'b1;
    start_addr = sa;
    count      = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (acc_cnt != a0) begin
        got = 1'b1;
        break;
      end
    end
    abort     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    check("abort_first_word", 32'(got), 32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_one_word", 32'(acc_cnt - a0), 32'd1);
    check("abort_idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int d0;
    rom_mem[0] = 8'hA0; rom_mem[1] = 8'h3C; rom_mem[2] = 8'h55; rom_mem[3] = 8'h54;
    rom_mem[4] = 8'hC1; rom_mem[5] = 8'h0F; rom_mem[6] = 8'h96; rom_mem[7] = 8'hE7;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a long run.
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(rom_mem[3'(5 + i)]);
    @(posedge clk); #1;
    out_ready = 1'b1; start = 1'b1; start_addr = 3'd5; count = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_rom_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_idle_valid", 32'(out_valid), 32'd0);

    run(3'd2, 4'd2, 0, 0, 1'b0);
    run(3'd6, 4'd4, 0, 0, 1'b0);
    run(3'd2, 4'd2, 2, 5, 1'b0);
    run(3'd3, 4'd0, 0, 0, 1'b0);
    abort_run(3'd6);

    // Abort together with start in IDLE must not launch a run.
    d0 = done_cnt;
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1; start_addr = 3'd1; count = 4'd3;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_start_valid", 32'(out_valid), 32'd0);
    check("abort_start_done", 32'(done_cnt - d0), 32'd0);

    run(3'd5, 4'd8, 1, 0, 1'b1);
    for (int r = 0; r < 25; r++) begin
      run(3'($urandom), 4'($urandom_range(0, 8)), int'($urandom_range(0, 1)), 0,
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
